// File: rtl/fixed_point_acc.sv
// fixed_point_acc
// ---------------
// Sums NUM_TERMS signed fixed-point samples (WIDTH bits, FRAC_BITS fractional
// bits) and presents each completed sum, converted back to WIDTH bits in the
// same Q format, in a one-entry output register with a valid/ready handshake.
//
// Optional feature macro: FIXED_POINT_ACC_SAT_EN
//   defined   -> out-of-range sums clip to the most positive / most negative
//                WIDTH-bit value and sat_out flags the clipped result.
//   undefined -> the result is the low WIDTH bits of the sum (wrap-around)
//                and sat_out is tied low.
//
// Ports
//   clk        in   single clock, rising-edge
//   rstn       in   asynchronous active-low reset
//   value_in   in   signed sample
//   valid_in   in   sample qualifier (single-cycle pulses, no backpressure)
//   clear_in   in   synchronous abort of the partial sum
//   ready_in   in   consumer accepts the held result
//   value_out  out  signed result, same Q format as value_in
//   valid_out  out  result held in the output register
//   sat_out    out  held result was clipped (qualified by valid_out)
//   drop_err   out  sticky: a completed result found the register full
//   fsm_state  out  output FSM state (0 = EMPTY, 1 = FULL)
//
// Handshake: the result transfers at a rising edge where valid_out and
// ready_in are both high. While valid_out is high and no transfer has
// happened, value_out and sat_out do not change. The sample side has no
// ready: every valid_in pulse with clear_in low is accepted.
module fixed_point_acc #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3,
  parameter int NUM_TERMS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] value_in,
  input  logic             valid_in,
  input  logic             clear_in,
  input  logic             ready_in,
  output logic [WIDTH-1:0] value_out,
  output logic             valid_out,
  output logic             sat_out,
  output logic             drop_err,
  output logic             fsm_state
);

  localparam int CW = $clog2(NUM_TERMS);
  localparam int AW = WIDTH + CW;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_TERMS - 1);

  if (FRAC_BITS <= 0 || FRAC_BITS >= WIDTH || NUM_TERMS < 2) begin : g_param_check
    $error("fixed_point_acc: illegal parameter combination");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic signed [AW-1:0]   acc;
  logic        [CW-1:0]   cnt;
  logic signed [AW-1:0]   sample_ext;
  logic signed [AW-1:0]   sum;
  logic                   accept;
  logic                   done;
  logic                   load;
  logic                   drop_set;
  logic        [WIDTH-1:0] res_val;
  logic                   res_sat;
  logic        [WIDTH-1:0] out_val;
  logic                   drop_q;

  // The accumulator is wide enough for NUM_TERMS full-scale samples, so the
  // running sum itself never overflows; only the final conversion can clip.
  assign sample_ext = {{CW{value_in[WIDTH-1]}}, value_in};
  assign sum        = acc + sample_ext;
  assign accept     = valid_in && !clear_in;
  assign done       = accept && (cnt == LAST_CNT);

  // --------------------------------------------------------------------
  // Conversion of the AW-bit sum back to WIDTH bits.
  // --------------------------------------------------------------------
`ifdef FIXED_POINT_ACC_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    res_val = sum[WIDTH-1:0];
    res_sat = 1'b0;
    if (sum > SAT_MAX) begin
      res_val = SAT_MAX[WIDTH-1:0];
      res_sat = 1'b1;
    end else if (sum < SAT_MIN) begin
      res_val = SAT_MIN[WIDTH-1:0];
      res_sat = 1'b1;
    end
  end
`else
  assign res_val = sum[WIDTH-1:0];
  assign res_sat = 1'b0;
`endif

  // --------------------------------------------------------------------
  // Accumulator and term counter. They keep running while a result is
  // pending so samples can arrive back-to-back indefinitely.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear_in) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------
  // Output FSM. A completion while FULL and not handshaken is discarded;
  // a completion coincident with a handshake reloads without a bubble.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop_set  = 1'b0;
    case (state)
      EMPTY: begin
        if (done) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (done && ready_in) begin
          load = 1'b1;
        end else if (done) begin
          drop_set = 1'b1;
        end else if (ready_in) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_val <= '0;
    end else if (load) begin
      out_val <= res_val;
    end
  end

`ifdef FIXED_POINT_ACC_SAT_EN
  logic out_sat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_sat <= 1'b0;
    end else if (load) begin
      out_sat <= res_sat;
    end
  end

  assign sat_out = out_sat;
`else
  assign sat_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_q <= 1'b0;
    end else if (drop_set) begin
      drop_q <= 1'b1;
    end
  end

  assign value_out = out_val;
  assign valid_out = (state == FULL);
  assign drop_err  = drop_q;
  assign fsm_state = (state == FULL);

endmodule
